// File: rtl/vtc_timing_detector_pkg.sv
// Shared definitions for the video timing detector.
//  - FSM state encoding for the lock state machine
//  - index map of the six-entry measurement vector used by the lock compare
//  - reference 640x480 mode constants, common with the timing controller benches
package vtc_timing_detector_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vtd_state_e;

  // Measurement vector layout (element 0 is the least significant slice)
  localparam int MEAS_N     = 6;
  localparam int M_H_TOTAL  = 0;
  localparam int M_H_SYNC_W = 1;
  localparam int M_H_ACTIVE = 2;
  localparam int M_V_TOTAL  = 3;
  localparam int M_V_SYNC_W = 4;
  localparam int M_V_ACTIVE = 5;

  // 640x480@60 reference timing
  localparam int MODE_640_H_TOTAL  = 800;
  localparam int MODE_640_H_SYNC   = 96;
  localparam int MODE_640_H_ACTIVE = 640;
  localparam int MODE_640_V_TOTAL  = 525;
  localparam int MODE_640_V_SYNC   = 2;
  localparam int MODE_640_V_ACTIVE = 480;

endpackage

// File: rtl/vtc_sync_measure.sv
// One-axis sync measurement: leading-edge detect plus period, sync-width and
// activity counters. Used per clock for the horizontal axis and per line
// (step = line start) for the vertical axis.
// Ports:
//  clock_in, reset  pixel clock, async active-low reset
//  step             advance this axis by one unit (clock or line)
//  sync_act         sync level for this step, already normalised to active-high
//  act              activity for this step (data enable, or "line had de")
//  lead             leading edge of sync seen on this step (combinational)
//  cnt_sat          period counter stuck at its maximum (no sync arriving)
//  period/width/active  values latched at the most recent leading edge
module vtc_sync_measure #(
  parameter int CNT_W     = 12,
  // 1: activity on the edge step belongs to the new period (H axis);
  // 0: it belongs to the period that is ending (V axis, flag of the finished line)
  parameter bit ACT_LEADS = 1'b1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             step,
  input  logic             sync_act,
  input  logic             act,
  output logic             lead,
  output logic             cnt_sat,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] active
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic             sync_prev;
  logic [CNT_W-1:0] cnt, wcnt, acnt, act_total;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  assign lead      = step & sync_act & ~sync_prev;
  assign cnt_sat   = (cnt == MAX);
  assign act_total = (!ACT_LEADS && act) ? sat_inc(acnt) : acnt;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      sync_prev <= 1'b0;
      cnt       <= '0;
      wcnt      <= '0;
      acnt      <= '0;
      period    <= '0;
      width     <= '0;
      active    <= '0;
    end else if (step) begin
      sync_prev <= sync_act;
      if (lead) begin
        // cnt counts steps since the previous edge minus one, so the
        // edge step itself is included in the period
        period <= cnt_sat ? MAX : cnt + 1'b1;
        width  <= wcnt;
        // blanking periods have no activity: keep the last nonzero count
        if (act_total != '0) active <= act_total;
        cnt    <= '0;
        wcnt   <= CNT_W'(1);
        acnt   <= (ACT_LEADS && act) ? CNT_W'(1) : '0;
      end else begin
        cnt <= sat_inc(cnt);
        if (sync_act) wcnt <= sat_inc(wcnt);
        if (act)      acnt <= sat_inc(acnt);
      end
    end
  end

endmodule

// File: rtl/vtc_timing_detector.sv
// Receive-side video timing detector. Registers hSync/vSync/video_active,
// measures line and frame timing, recovers active-region pixel coordinates
// and declares lock once LOCK_FRAMES identical frame measurements are seen.
// Ports:
//  clock_in, reset        pixel clock, async active-low reset
//  hSync, vSync           syncs, active level set by SYNC_POL
//  video_active           data enable from the timing source
//  locked, timing_change  lock status and 1-clock "lost lock on mismatch" pulse
//  h_*/v_*                published measurements (last locked set)
//  pixel_x/pixel_y/de_out active-region coordinates, 2 clocks after the inputs
module vtc_timing_detector
  import vtc_timing_detector_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             hSync,
  input  logic             vSync,
  input  logic             video_active,
  output logic             locked,
  output logic             timing_change,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync_w,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             de_out
);
  localparam logic [CNT_W-1:0] MAX     = '1;
  localparam logic [7:0]       LOCK_M1 = 8'(LOCK_FRAMES - 1);

  typedef logic [MEAS_N-1:0][CNT_W-1:0] meas_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  // ---------------- input registers (normalised to active-high sync)
  logic hs_a, vs_a, de_r;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      hs_a <= 1'b0;
      vs_a <= 1'b0;
      de_r <= 1'b0;
    end else begin
      hs_a <= (hSync == SYNC_POL);
      vs_a <= (vSync == SYNC_POL);
      de_r <= video_active;
    end
  end

  // ---------------- axis measurement
  logic             hle, fs, h_sat, v_sat, line_de;
  logic [CNT_W-1:0] h_per, h_wid, h_act, v_per, v_wid, v_act;

  vtc_sync_measure #(.CNT_W(CNT_W), .ACT_LEADS(1'b1)) u_h_meas (
    .clock_in (clock_in),
    .reset    (reset),
    .step     (1'b1),
    .sync_act (hs_a),
    .act      (de_r),
    .lead     (hle),
    .cnt_sat  (h_sat),
    .period   (h_per),
    .width    (h_wid),
    .active   (h_act)
  );

  // vSync is only looked at on line starts; the activity fed in on a line
  // start is the flag of the line that just ended
  vtc_sync_measure #(.CNT_W(CNT_W), .ACT_LEADS(1'b0)) u_v_meas (
    .clock_in (clock_in),
    .reset    (reset),
    .step     (hle),
    .sync_act (vs_a),
    .act      (line_de),
    .lead     (fs),
    .cnt_sat  (v_sat),
    .period   (v_per),
    .width    (v_wid),
    .active   (v_act)
  );

  // ---------------- coordinates
  logic [CNT_W-1:0] x_cnt, y_cnt, x_base, y_base;

  // de on the line-start clock already belongs to the new line
  assign x_base = hle ? '0 : x_cnt;
  assign y_base = fs                ? '0 :
                  (hle && line_de)  ? sat_inc(y_cnt) : y_cnt;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      line_de <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
      de_out  <= 1'b0;
    end else begin
      line_de <= hle ? de_r : (line_de | de_r);
      x_cnt   <= de_r ? sat_inc(x_base) : x_base;
      y_cnt   <= y_base;
      pixel_x <= de_r ? x_base : '0;
      pixel_y <= de_r ? y_base : '0;
      de_out  <= de_r;
    end
  end

  // ---------------- lock FSM
  // Runs one clock after frame start so the line that closed on the
  // frame-start clock is already folded into the H and V measurements.
  vtd_state_e state;
  logic       fs_d, any_sat, match;
  logic [7:0] match_cnt, mc_inc;
  meas_t      meas_now, stored, pub;

  assign meas_now = {v_act, v_wid, v_per, h_act, h_wid, h_per};

  always_comb begin
    any_sat = 1'b0;
    for (int i = 0; i < MEAS_N; i++) any_sat = any_sat | (meas_now[i] == MAX);
  end

  // a saturated measurement never counts as a match, so it is never published
  assign match  = (meas_now == stored) && !any_sat;
  assign mc_inc = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state         <= SEARCH;
      fs_d          <= 1'b0;
      locked        <= 1'b0;
      timing_change <= 1'b0;
      match_cnt     <= '0;
      stored        <= '0;
      pub           <= '0;
    end else begin
      fs_d          <= fs;
      timing_change <= 1'b0;
      if (h_sat || v_sat) begin
        // sync has gone away: drop lock silently
        state     <= SEARCH;
        locked    <= 1'b0;
        match_cnt <= '0;
      end else if (fs_d) begin
        case (state)
          SEARCH: begin
            // the frame before the first frame start is partial: forget it
            state     <= MEASURE;
            match_cnt <= '0;
            stored    <= '0;
          end
          MEASURE: begin
            stored <= meas_now;
            if (match) begin
              match_cnt <= mc_inc;
              if (mc_inc >= LOCK_M1) begin
                state  <= LOCKED;
                locked <= 1'b1;
                pub    <= meas_now;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              state         <= MEASURE;
              locked        <= 1'b0;
              timing_change <= 1'b1;
              stored        <= meas_now;
              match_cnt     <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign h_total  = pub[M_H_TOTAL];
  assign h_sync_w = pub[M_H_SYNC_W];
  assign h_active = pub[M_H_ACTIVE];
  assign v_total  = pub[M_V_TOTAL];
  assign v_sync_w = pub[M_V_SYNC_W];
  assign v_active = pub[M_V_ACTIVE];

endmodule

// File: tb/tb_vtc_timing_detector.sv
// Bench for vtc_timing_detector. Two instances share one stimulus: an
// active-low-sync DUT and an active-high-sync DUT fed inverted syncs. Small
// video modes keep frames short; mode geometry and expected measurements
// sit side by side in a table.
module tb_vtc_timing_detector;
  import vtc_timing_detector_pkg::*;

  typedef struct {
    int ht, hs, hb, ha, vt, vs, vb, va;
    int e_ht, e_hs, e_ha, e_vt, e_vs, e_va;
  } vec_t;

  localparam int FULL = 1 << 30;

  logic clock_in = 1'b0;
  logic reset;
  logic h_lvl, v_lvl, de;

  logic        locked1, tc1, deo1, locked2, tc2, deo2;
  logic [11:0] ht1, hsw1, ha1, vt1, vsw1, va1, px1, py1;
  logic [11:0] ht2, hsw2, ha2, vt2, vsw2, va2, px2, py2;

  int checks = 0, failures = 0;
  int tc_cnt = 0, tc_cnt2 = 0, de_cnt = 0, de_cnt2 = 0;
  int fx = -1, fy = -1, lx = -1, ly = -1, lx2 = -1, ly2 = -1;
  bit seen = 1'b0;
  vec_t tbl [3];

  always #5 clock_in = ~clock_in;

  vtc_timing_detector #(.CNT_W(12), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut (
    .clock_in(clock_in), .reset(reset), .hSync(~h_lvl), .vSync(~v_lvl), .video_active(de),
    .locked(locked1), .timing_change(tc1), .h_total(ht1), .h_sync_w(hsw1), .h_active(ha1),
    .v_total(vt1), .v_sync_w(vsw1), .v_active(va1), .pixel_x(px1), .pixel_y(py1), .de_out(deo1)
  );

  vtc_timing_detector #(.CNT_W(12), .SYNC_POL(1'b1), .LOCK_FRAMES(2)) dut_pos (
    .clock_in(clock_in), .reset(reset), .hSync(h_lvl), .vSync(v_lvl), .video_active(de),
    .locked(locked2), .timing_change(tc2), .h_total(ht2), .h_sync_w(hsw2), .h_active(ha2),
    .v_total(vt2), .v_sync_w(vsw2), .v_active(va2), .pixel_x(px2), .pixel_y(py2), .de_out(deo2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sample outputs on the falling edge, then present the next inputs
  task automatic tick(input logic h, input logic v, input logic d);
    @(negedge clock_in);
    tc_cnt  += int'(tc1);
    tc_cnt2 += int'(tc2);
    if (deo1) begin
      if (!seen) begin fx = int'(px1); fy = int'(py1); seen = 1'b1; end
      lx = int'(px1); ly = int'(py1); de_cnt++;
    end
    if (deo2) begin lx2 = int'(px2); ly2 = int'(py2); de_cnt2++; end
    h_lvl = h; v_lvl = v; de = d;
  endtask

  // sync first, then back porch, active, front porch on both axes
  task automatic drive_frame(input vec_t m, input int n_ticks);
    int n = 0;
    for (int ln = 0; ln < m.vt; ln++)
      for (int px = 0; px < m.ht; px++) begin
        if (n == n_ticks) return;
        tick(px < m.hs, ln < m.vs,
             (ln >= m.vb) && (ln < m.vb + m.va) && (px >= m.hb) && (px < m.hb + m.ha));
        n++;
      end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_monitors();
    seen = 1'b0; de_cnt = 0; de_cnt2 = 0; tc_cnt = 0; tc_cnt2 = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; lx2 = -1; ly2 = -1;
  endtask

  initial begin
    vec_t m2;
    reset = 1'b0; h_lvl = 1'b0; v_lvl = 1'b0; de = 1'b0;
    //           ht hs hb ha  vt vs vb va | h_tot h_sw h_act v_tot v_sw v_act
    tbl[0] = '{20, 3, 5, 12, 12, 2, 4, 6,   20,   3,   12,   12,   2,   6};
    tbl[1] = '{24, 4, 6, 16, 10, 1, 3, 5,   24,   4,   16,   10,   1,   5};
    tbl[2] = '{16, 2, 3, 10,  9, 3, 4, 4,   16,   2,   10,    9,   3,   4};

    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("reset_outputs", 32'(|{locked1, tc1, deo1, ht1, hsw1, ha1, vt1, vsw1, va1, px1, py1}), 0);
    check("reset_outputs_pos", 32'(|{locked2, tc2, deo2, ht2, hsw2, ha2, vt2, vsw2, va2, px2, py2}), 0);

    // ---- table: lock after third frame start and report each mode
    for (int i = 0; i < 3; i++) begin
      do_reset();
      drive_frame(tbl[i], FULL);
      drive_frame(tbl[i], FULL);
      check($sformatf("t%0d_prelock", i), 32'(locked1), 0);
      check($sformatf("t%0d_prelock_pos", i), 32'(locked2), 0);
      drive_frame(tbl[i], tbl[i].ht);
      check($sformatf("t%0d_locked", i),   32'(locked1), 1);
      check($sformatf("t%0d_h_total", i),  32'(ht1),  tbl[i].e_ht);
      check($sformatf("t%0d_h_sync_w", i), 32'(hsw1), tbl[i].e_hs);
      check($sformatf("t%0d_h_active", i), 32'(ha1),  tbl[i].e_ha);
      check($sformatf("t%0d_v_total", i),  32'(vt1),  tbl[i].e_vt);
      check($sformatf("t%0d_v_sync_w", i), 32'(vsw1), tbl[i].e_vs);
      check($sformatf("t%0d_v_active", i), 32'(va1),  tbl[i].e_va);
      check($sformatf("t%0d_locked_pos", i),   32'(locked2), 1);
      check($sformatf("t%0d_h_total_pos", i),  32'(ht2),  tbl[i].e_ht);
      check($sformatf("t%0d_h_sync_w_pos", i), 32'(hsw2), tbl[i].e_hs);
      check($sformatf("t%0d_h_active_pos", i), 32'(ha2),  tbl[i].e_ha);
      check($sformatf("t%0d_v_total_pos", i),  32'(vt2),  tbl[i].e_vt);
      check($sformatf("t%0d_v_sync_w_pos", i), 32'(vsw2), tbl[i].e_vs);
      check($sformatf("t%0d_v_active_pos", i), 32'(va2),  tbl[i].e_va);
    end

    // ---- coordinates over one locked frame (mode 0: 12x6 active)
    do_reset();
    repeat (3) drive_frame(tbl[0], FULL);
    reset_monitors();
    drive_frame(tbl[0], FULL);
    check("px_first_x", 32'(fx), 0);
    check("px_first_y", 32'(fy), 0);
    check("px_last_x",  32'(lx), 11);
    check("px_last_y",  32'(ly), 5);
    check("de_count",   32'(de_cnt), 72);
    check("px_last_x_pos", 32'(lx2), 11);
    check("px_last_y_pos", 32'(ly2), 5);
    check("de_count_pos",  32'(de_cnt2), 72);

    // ---- line length 20 -> 24
    m2 = tbl[0];
    m2.ht = 24;
    drive_frame(m2, FULL);
    check("chg_still_locked", 32'(locked1), 1);
    check("chg_no_tc_yet", 32'(tc_cnt), 0);
    drive_frame(m2, FULL);
    check("chg_tc_once", 32'(tc_cnt), 1);
    check("chg_tc_once_pos", 32'(tc_cnt2), 1);
    check("chg_unlocked", 32'(locked1), 0);
    check("chg_hold_h_total", 32'(ht1), 20);
    drive_frame(m2, m2.ht);
    check("chg_relocked", 32'(locked1), 1);
    check("chg_new_h_total", 32'(ht1), 24);
    check("chg_new_h_total_pos", 32'(ht2), 24);
    check("chg_tc_total", 32'(tc_cnt), 1);

    // ---- watchdog: hSync held inactive
    tc_cnt = 0;
    repeat (3900) tick(1'b0, 1'b0, 1'b0);
    check("wd_before_sat", 32'(locked1), 1);
    repeat (300) tick(1'b0, 1'b0, 1'b0);
    check("wd_unlocked", 32'(locked1), 0);
    check("wd_unlocked_pos", 32'(locked2), 0);
    check("wd_no_tc", 32'(tc_cnt), 0);
    check("wd_state", 32'(dut.state), 32'(SEARCH));
    check("wd_hold_h_total", 32'(ht1), 24);
    // vSync was active on the last line start before the gap, so the
    // first frame after the gap does not produce a frame start
    repeat (3) drive_frame(m2, FULL);
    check("wd_prerelock", 32'(locked1), 0);
    drive_frame(m2, m2.ht);
    check("wd_relock", 32'(locked1), 1);

    // ---- reset in the middle of a frame
    drive_frame(m2, 150);
    check("mid_locked_before", 32'(locked1), 1);
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(|{locked1, tc1, deo1, ht1, hsw1, ha1, vt1, vsw1, va1, px1, py1}), 0);
    check("mid_reset_outputs_pos", 32'(|{locked2, tc2, deo2, ht2, hsw2, ha2, vt2, vsw2, va2, px2, py2}), 0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    drive_frame(tbl[0], FULL);
    drive_frame(tbl[0], FULL);
    check("mid_prelock", 32'(locked1), 0);
    drive_frame(tbl[0], tbl[0].ht);
    check("mid_relock", 32'(locked1), 1);
    check("mid_h_total", 32'(ht1), 20);
    check("mid_v_total", 32'(vt1), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
